// File: rtl/exu_lsu_ctrl_if.sv
// ----------------------------------------------------------------------------
// exu_lsu_ctrl_if
// Bundles the four handshake channels around the LSU controller:
//   - AGU command channel      (agu_cmd_*)
//   - DTCM command channel     (dtcm_cmd_*)
//   - DTCM response channel    (dtcm_rsp_*)
//   - write-back/commit channel (lsu_o_*)
// Modports:
//   master : the LSU controller side (accepts AGU commands, issues DTCM
//            commands, accepts DTCM responses, drives write-back)
//   slave  : the surrounding environment (AGU, DTCM and write-back consumer)
// ----------------------------------------------------------------------------
interface exu_lsu_ctrl_if #(
  parameter int XLEN            = 32,
  parameter int DTCM_ADDR_WIDTH = 16,
  parameter int ITAG_WIDTH      = 2
);

  // AGU command channel
  logic                       agu_cmd_valid;
  logic                       agu_cmd_ready;
  logic [DTCM_ADDR_WIDTH-1:0] agu_cmd_addr;
  logic                       agu_cmd_read;
  logic [XLEN-1:0]            agu_cmd_wdata;
  logic [XLEN/8-1:0]          agu_cmd_wmask;
  logic [ITAG_WIDTH-1:0]      agu_cmd_itag;
  logic                       agu_cmd_usign;
  logic [1:0]                 agu_cmd_size;

  // DTCM command channel
  logic                       dtcm_cmd_valid;
  logic                       dtcm_cmd_ready;
  logic [DTCM_ADDR_WIDTH-1:0] dtcm_cmd_addr;
  logic                       dtcm_cmd_read;
  logic [XLEN-1:0]            dtcm_cmd_wdata;
  logic [XLEN/8-1:0]          dtcm_cmd_wmask;

  // DTCM response channel
  logic                       dtcm_rsp_valid;
  logic                       dtcm_rsp_ready;
  logic [XLEN-1:0]            dtcm_rsp_rdata;
  logic                       dtcm_rsp_err;

  // Write-back / commit channel
  logic                       lsu_o_valid;
  logic                       lsu_o_ready;
  logic [XLEN-1:0]            lsu_o_wbck_wdat;
  logic [ITAG_WIDTH-1:0]      lsu_o_wbck_itag;
  logic                       lsu_o_wbck_err;
  logic                       lsu_o_cmt_load;
  logic                       lsu_o_cmt_store;

  modport master (
    input  agu_cmd_valid, agu_cmd_addr, agu_cmd_read, agu_cmd_wdata,
           agu_cmd_wmask, agu_cmd_itag, agu_cmd_usign, agu_cmd_size,
    output agu_cmd_ready,
    output dtcm_cmd_valid, dtcm_cmd_addr, dtcm_cmd_read, dtcm_cmd_wdata,
           dtcm_cmd_wmask,
    input  dtcm_cmd_ready,
    input  dtcm_rsp_valid, dtcm_rsp_rdata, dtcm_rsp_err,
    output dtcm_rsp_ready,
    output lsu_o_valid, lsu_o_wbck_wdat, lsu_o_wbck_itag, lsu_o_wbck_err,
           lsu_o_cmt_load, lsu_o_cmt_store,
    input  lsu_o_ready
  );

  modport slave (
    output agu_cmd_valid, agu_cmd_addr, agu_cmd_read, agu_cmd_wdata,
           agu_cmd_wmask, agu_cmd_itag, agu_cmd_usign, agu_cmd_size,
    input  agu_cmd_ready,
    input  dtcm_cmd_valid, dtcm_cmd_addr, dtcm_cmd_read, dtcm_cmd_wdata,
           dtcm_cmd_wmask,
    output dtcm_cmd_ready,
    output dtcm_rsp_valid, dtcm_rsp_rdata, dtcm_rsp_err,
    input  dtcm_rsp_ready,
    input  lsu_o_valid, lsu_o_wbck_wdat, lsu_o_wbck_itag, lsu_o_wbck_err,
           lsu_o_cmt_load, lsu_o_cmt_store,
    output lsu_o_ready
  );

endinterface

// File: rtl/exu_lsu_ctrl.sv
// ----------------------------------------------------------------------------
// exu_lsu_ctrl
// LSU control between the AGU command channel and the DTCM bus port.
// Commands pass straight through to the DTCM (word-aligned address) while an
// in-order FIFO remembers {read, usign, size, addr[1:0], itag} for each
// outstanding access. Each DTCM response is aligned/extended using the FIFO
// head and loaded into a registered write-back buffer.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   bus           : exu_lsu_ctrl_if.master (AGU cmd, DTCM cmd/rsp, write-back)
//   lsu_active    : outstanding entries exist or write-back buffer is valid
//   lsu_outs_cnt  : number of outstanding DTCM transactions
// ----------------------------------------------------------------------------
module exu_lsu_ctrl #(
  parameter int XLEN            = 32,
  parameter int DTCM_ADDR_WIDTH = 16,
  parameter int ITAG_WIDTH      = 2,
  parameter int OUTS_DEPTH      = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  exu_lsu_ctrl_if.master                bus,
  output logic                          lsu_active,
  output logic [$clog2(OUTS_DEPTH):0]   lsu_outs_cnt
);

  localparam int CW = $clog2(OUTS_DEPTH) + 1;
  localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;

  typedef struct packed {
    logic                  read;
    logic                  usign;
    logic [1:0]            size;
    logic [1:0]            off;
    logic [ITAG_WIDTH-1:0] itag;
  } entry_t;

  // Shift the addressed lane down to bit 0 and sign/zero-extend by size.
  function automatic logic [XLEN-1:0] load_align(
    input logic [XLEN-1:0] rdata,
    input logic [1:0]      off,
    input logic [1:0]      size,
    input logic            usign
  );
    logic [XLEN-1:0] sh;
    sh = rdata >> {off, 3'b000};
    case (size)
      2'b00:   load_align = {{(XLEN-8){~usign & sh[7]}}, sh[7:0]};
      2'b01:   load_align = {{(XLEN-16){~usign & sh[15]}}, sh[15:0]};
      default: load_align = rdata;
    endcase
  endfunction

  // Pointers wrap at OUTS_DEPTH, which need not fill the pointer width.
  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    if (p == PW'(OUTS_DEPTH - 1)) begin
      ptr_next = {PW{1'b0}};
    end else begin
      ptr_next = p + PW'(1);
    end
  endfunction

  entry_t            fifo_r [OUTS_DEPTH];
  logic [PW-1:0]     wr_ptr_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [CW-1:0]     cnt_r;

  logic              wb_vld_r;
  logic [XLEN-1:0]   wb_wdat_r;
  logic [ITAG_WIDTH-1:0] wb_itag_r;
  logic              wb_err_r;
  logic              wb_load_r;
  logic              wb_store_r;

  logic              full_s;
  logic              empty_s;
  logic              push_s;
  logic              pop_s;
  logic              wb_fire_s;
  entry_t            head_s;
  entry_t            push_entry_s;
  logic [XLEN-1:0]   rsp_data_s;

  assign full_s  = (cnt_r == CW'(OUTS_DEPTH));
  assign empty_s = (cnt_r == {CW{1'b0}});

  // Command path: no bypass, a full FIFO blocks the AGU even if a pop happens.
  assign bus.dtcm_cmd_valid = bus.agu_cmd_valid & ~full_s;
  assign bus.agu_cmd_ready  = bus.dtcm_cmd_ready & ~full_s;
  assign bus.dtcm_cmd_addr  = {bus.agu_cmd_addr[DTCM_ADDR_WIDTH-1:2], 2'b00};
  assign bus.dtcm_cmd_read  = bus.agu_cmd_read;
  assign bus.dtcm_cmd_wdata = bus.agu_cmd_wdata;
  assign bus.dtcm_cmd_wmask = bus.agu_cmd_wmask;

  // A response is taken only when it has a matching entry and somewhere to go.
  assign bus.dtcm_rsp_ready = ~empty_s & (~wb_vld_r | bus.lsu_o_ready);

  assign push_s    = bus.agu_cmd_valid & bus.agu_cmd_ready;
  assign pop_s     = bus.dtcm_rsp_valid & bus.dtcm_rsp_ready;
  assign wb_fire_s = wb_vld_r & bus.lsu_o_ready;

  assign head_s = fifo_r[rd_ptr_r];

  assign push_entry_s.read  = bus.agu_cmd_read;
  assign push_entry_s.usign = bus.agu_cmd_usign;
  assign push_entry_s.size  = bus.agu_cmd_size;
  assign push_entry_s.off   = bus.agu_cmd_addr[1:0];
  assign push_entry_s.itag  = bus.agu_cmd_itag;

  // Write-back data for the response at the FIFO head; errors and stores give 0.
  always_comb begin
    rsp_data_s = {XLEN{1'b0}};
    if (bus.dtcm_rsp_err) begin
      rsp_data_s = {XLEN{1'b0}};
    end else if (head_s.read) begin
      rsp_data_s = load_align(bus.dtcm_rsp_rdata, head_s.off, head_s.size, head_s.usign);
    end else begin
      rsp_data_s = {XLEN{1'b0}};
    end
  end

  // Outstanding FIFO pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      cnt_r    <= {CW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Outstanding FIFO entry storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUTS_DEPTH; i++) begin
        fifo_r[i] <= '0;
      end
    end else if (push_s) begin
      fifo_r[wr_ptr_r] <= push_entry_s;
    end
  end

  // Write-back buffer: a pop reloads it even while the old result drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_vld_r   <= 1'b0;
      wb_wdat_r  <= {XLEN{1'b0}};
      wb_itag_r  <= {ITAG_WIDTH{1'b0}};
      wb_err_r   <= 1'b0;
      wb_load_r  <= 1'b0;
      wb_store_r <= 1'b0;
    end else if (pop_s) begin
      wb_vld_r   <= 1'b1;
      wb_wdat_r  <= rsp_data_s;
      wb_itag_r  <= head_s.itag;
      wb_err_r   <= bus.dtcm_rsp_err;
      wb_load_r  <= head_s.read;
      wb_store_r <= ~head_s.read;
    end else if (wb_fire_s) begin
      wb_vld_r   <= 1'b0;
    end
  end

  assign bus.lsu_o_valid     = wb_vld_r;
  assign bus.lsu_o_wbck_wdat = wb_wdat_r;
  assign bus.lsu_o_wbck_itag = wb_itag_r;
  assign bus.lsu_o_wbck_err  = wb_err_r;
  assign bus.lsu_o_cmt_load  = wb_load_r;
  assign bus.lsu_o_cmt_store = wb_store_r;

  assign lsu_active   = ~empty_s | wb_vld_r;
  assign lsu_outs_cnt = cnt_r;

endmodule

// File: doc/exu_lsu_ctrl.md
# exu_lsu_ctrl

LSU control block between the AGU command channel and the DTCM bus port. It forwards aligned load/store commands to the DTCM and tracks up to OUTS_DEPTH outstanding transactions in an in-order FIFO. It aligns and sign/zero-extends load response data, then returns a registered write-back/commit result tagged with the instruction ITAG. It also reports outstanding activity to the dispatch and OITF logic.

## Interface
Parameters:
- XLEN, 32, data width (only 32 supported)
- DTCM_ADDR_WIDTH, 16, DTCM byte-address width
- ITAG_WIDTH, 2, instruction tag width
- OUTS_DEPTH, 2, outstanding-FIFO entries (power of two, ≥1)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - clk  in  1  clock
  - rst_n  in  1  asynchronous active-low reset
- AGU command channel:
  - agu_cmd_valid  in  1  AGU command valid
  - agu_cmd_ready  out  1  command accepted
  - agu_cmd_addr  in  DTCM_ADDR_WIDTH  byte address (AGU guarantees natural alignment)
  - agu_cmd_read  in  1  1 = load, 0 = store
  - agu_cmd_wdata  in  XLEN  lane-replicated store data
  - agu_cmd_wmask  in  XLEN/8  byte-enable mask
  - agu_cmd_itag  in  ITAG_WIDTH  instruction tag
  - agu_cmd_usign  in  1  unsigned load
  - agu_cmd_size  in  2  00 byte, 01 half, 10 word
- DTCM command channel:
  - dtcm_cmd_valid  out  1  DTCM command valid
  - dtcm_cmd_ready  in  1  DTCM accepts command
  - dtcm_cmd_addr  out  DTCM_ADDR_WIDTH  word-aligned address ({addr[W-1:2],2'b00})
  - dtcm_cmd_read  out  1  read/write
  - dtcm_cmd_wdata  out  XLEN  store data
  - dtcm_cmd_wmask  out  XLEN/8  byte mask
- DTCM response channel:
  - dtcm_rsp_valid  in  1  response valid
  - dtcm_rsp_ready  out  1  response accepted
  - dtcm_rsp_rdata  in  XLEN  raw read word
  - dtcm_rsp_err  in  1  bus error
- Write-back/commit channel:
  - lsu_o_valid  out  1  write-back/commit valid
  - lsu_o_ready  in  1  write-back accepted
  - lsu_o_wbck_wdat  out  XLEN  extended load data (0 for stores)
  - lsu_o_wbck_itag  out  ITAG_WIDTH  tag of the completing instruction
  - lsu_o_wbck_err  out  1  bus error
  - lsu_o_cmt_load  out  1  completing op is a load
  - lsu_o_cmt_store  out  1  completing op is a store
- Status:
  - lsu_active  out  1  outstanding count ≠ 0, or write-back buffer valid
  - lsu_outs_cnt  out  $clog2(OUTS_DEPTH)+1  outstanding count

## Operation
- Outstanding FIFO:
  - Entry = {read, usign, size, addr[1:0], itag}.
  - Pointers wrap modulo OUTS_DEPTH.
  - cnt is an explicit counter of width $clog2(OUTS_DEPTH)+1.
- Command path is combinational and has no bypass when full:
  - dtcm_cmd_valid = agu_cmd_valid & ~full.
  - agu_cmd_ready = dtcm_cmd_ready & ~full.
  - Push occurs on agu_cmd_valid & agu_cmd_ready.
  - Address, read, wdata and wmask pass through; the address is forced word-aligned.
- Response path:
  - dtcm_rsp_ready = ~empty & (~wb_vld | lsu_o_ready).
  - Pop occurs on dtcm_rsp_valid & dtcm_rsp_ready.
  - On pop, the FIFO head plus processed data load the write-back buffer: wb_vld, wdat, itag, err, load, store.
- Load data processing:
  - sh = rdata >> (addr[1:0]*8).
  - Byte: {24{~usign & sh[7]}, sh[7:0]}.
  - Half: {16{~usign & sh[15]}, sh[15:0]}.
  - Word: rdata.
  - Stores return wdat = 0.
  - On err, wdat = 0; itag and the cmt flags are still reported.
- Write-back buffer:
  - Set on pop.
  - Cleared on lsu_o_valid & lsu_o_ready without a simultaneous pop.
  - Reloaded if both happen in the same cycle.
- Push and pop in the same cycle leave cnt unchanged.
- A response arriving while the FIFO is empty is not accepted (dtcm_rsp_ready = 0).

## Timing
- Reset values:
  - cnt = 0, pointers = 0, wb_vld = 0.
  - All outputs 0 except those driven combinationally from inputs (dtcm_cmd_* pass-through and agu_cmd_ready follow inputs).
- Command latency is 0 cycles: AGU to DTCM in the same cycle.
- Response latency is 1 cycle: DTCM response accepted at cycle N appears as lsu_o_valid at N+1.
- Full-throughput steady state: one command per cycle and one write-back per cycle.
- Back-pressure: lsu_o_ready = 0 with wb_vld = 1 stalls dtcm_rsp_ready, so the FIFO fills and agu_cmd_ready drops.
- Completions are strictly in issue order.
- Reset mid-operation discards all outstanding entries and the write-back buffer immediately (asynchronous).

## Test plan
- Word load:
  - Stimulus: addr 0x0010, size 10, itag 1; DTCM returns 0xDEADBEEF one cycle later.
  - Required: lsu_o_valid one cycle after the response; wdat 0xDEADBEEF, itag 1, cmt_load = 1.
- Signed byte load:
  - Stimulus: addr 0x0013, size 00, usign 0; rdata 0x80123456.
  - Required: wdat 0xFFFFFF80.
  - Repeat with usign 1: wdat 0x00000080.
- Halfword load:
  - Stimulus: addr 0x0002, usign 0; rdata 0x9ABC0000.
  - Required: wdat 0xFFFF9ABC.
- Store:
  - Stimulus: addr 0x0005, wmask 0010, wdata 0x55555555.
  - Required: dtcm_cmd_addr 0x0004, wmask 0010.
  - Required completion: cmt_store = 1, wdat 0.
  - With dtcm_rsp_err = 1: wbck_err = 1.
- Full / back-pressure (OUTS_DEPTH = 2, lsu_o_ready = 0):
  - Stimulus: issue 3 back-to-back loads.
  - Required: the third load sees agu_cmd_ready = 0, lsu_outs_cnt = 2, lsu_active = 1.
  - Required on releasing ready: three completions in order with itags 0, 1, 2.
- Reset mid-flight:
  - Stimulus: assert rst_n = 0 with 2 outstanding entries and wb_vld = 1.
  - Required: lsu_o_valid = 0, lsu_outs_cnt = 0, lsu_active = 0 immediately.
  - Required: a stray dtcm_rsp_valid after reset sees dtcm_rsp_ready = 0.
